// File: rtl/regfile_sb.sv
// Register file with N combinational read ports, one synchronous write port,
// optional write-to-read bypass and a per-register busy scoreboard with a count.
module regfile_sb #(
  parameter int unsigned DATA_W   = 32'd32,
  parameter int unsigned ADDR_W   = 32'd5,
  parameter int unsigned NREAD    = 32'd2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREAD*ADDR_W-1:0]   ra,
  output logic [NREAD*DATA_W-1:0]   rd,
  output logic [NREAD-1:0]          rd_busy,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         wa,
  input  logic [DATA_W-1:0]         wd,
  input  logic                      alloc_en,
  input  logic [ADDR_W-1:0]         alloc_addr,
  output logic [ADDR_W:0]           busy_count
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  logic [DATA_W-1:0] rf_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic [ADDR_W:0]   busy_count_r;

  logic              we_eff_s;
  logic              alloc_eff_s;
  logic              rule_a_s;
  logic              inc_s;
  logic              dec_s;
  logic [ADDR_W-1:0] ra_s [NREAD];

  assign busy_count = busy_count_r;

  // Qualify write/alloc (address 0 is inert when hardwired) and derive count deltas.
  always_comb begin
    we_eff_s    = we && !(ZERO_REG && (wa == '0));
    alloc_eff_s = alloc_en && !(ZERO_REG && (alloc_addr == '0));
    rule_a_s    = we_eff_s && alloc_eff_s && (wa == alloc_addr);
    inc_s       = alloc_eff_s && !busy_r[alloc_addr];
    // A new producer on the same register keeps it busy, so no decrement.
    dec_s       = we_eff_s && busy_r[wa] && !rule_a_s;
  end

  // Register array storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        rf_r[i] <= '0;
      end
    end else if (we_eff_s) begin
      rf_r[wa] <= wd;
    end
  end

  // Busy scoreboard; alloc is applied last so it wins over a same-address write.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= '0;
    end else begin
      if (we_eff_s) begin
        busy_r[wa] <= 1'b0;
      end
      if (alloc_eff_s) begin
        busy_r[alloc_addr] <= 1'b1;
      end
    end
  end

  // Busy counter tracking the number of set busy bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_count_r <= '0;
    end else begin
      busy_count_r <= busy_count_r + {{ADDR_W{1'b0}}, inc_s} - {{ADDR_W{1'b0}}, dec_s};
    end
  end

  // Combinational read ports with zero-register masking and optional bypass.
  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int p = 0; p < int'(NREAD); p++) begin
      ra_s[p] = ra[p*ADDR_W +: ADDR_W];
      if (ZERO_REG && (ra_s[p] == '0)) begin
        rd[p*DATA_W +: DATA_W] = '0;
        rd_busy[p]             = 1'b0;
      end else if (BYPASS && we_eff_s && !reset && (wa == ra_s[p])) begin
        rd[p*DATA_W +: DATA_W] = wd;
        rd_busy[p]             = alloc_eff_s && (alloc_addr == ra_s[p]);
      end else begin
        rd[p*DATA_W +: DATA_W] = rf_r[ra_s[p]];
        rd_busy[p]             = busy_r[ra_s[p]];
      end
    end
  end

endmodule
